// File: rtl/bpred_pkg.sv
// Shared types and helpers for the branch predictor: counter encodings, index modes,
// init FSM states and the saturating counter update.
package bpred_pkg;

   typedef enum logic [1:0] {
      CNT_SNT = 2'b00,
      CNT_WNT = 2'b01,
      CNT_WT  = 2'b10,
      CNT_ST  = 2'b11
   } cnt_e;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } init_state_e;

   localparam int MODE_BIMODAL = 0;
   localparam int MODE_GSHARE  = 1;
   localparam int MODE_CONCAT  = 2;

   function automatic logic [1:0] sat_incdec(input logic [1:0] cnt, input logic taken);
      logic [1:0] res;
      if (taken) begin
         res = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
      end else begin
         res = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
      end
      return res;
   endfunction

endpackage

// File: rtl/bpred_ras.sv
// Circular return address stack. A push when full overwrites the oldest entry;
// push and pop together replace the top without changing the depth.
module bpred_ras #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] push_data,
   output logic        empty,
   output logic [31:0] top
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [31:0]    mem_r [DEPTH];
   logic [PTR_W-1:0] ptr_r;
   logic [PTR_W:0]   cnt_r;
   logic [PTR_W-1:0] top_ptr_s;
   logic             full_s;

   assign top_ptr_s = ptr_r - PTR_W'(1);
   assign empty     = (cnt_r == '0);
   assign full_s    = (cnt_r == (PTR_W+1)'(DEPTH));
   assign top       = empty ? 32'h0000_0000 : mem_r[top_ptr_s];

   // Stack storage, write pointer and occupancy
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ptr_r <= '0;
         cnt_r <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= 32'h0000_0000;
         end
      end else if (push && pop && !empty) begin
         mem_r[top_ptr_s] <= push_data;
      end else if (push) begin
         mem_r[ptr_r] <= push_data;
         ptr_r        <= ptr_r + PTR_W'(1);
         if (!full_s) begin
            cnt_r <= cnt_r + (PTR_W+1)'(1);
         end
      end else if (pop && !empty) begin
         ptr_r <= ptr_r - PTR_W'(1);
         cnt_r <= cnt_r - (PTR_W+1)'(1);
      end
   end

endmodule

// File: rtl/bpred_unit.sv
// Branch predictor: 2-bit counter BHT with selectable indexing, global history,
// reset-time table sweep, return address stack and resolve statistics.
module bpred_unit
   import bpred_pkg::*;
#(
   parameter int IDX_W     = 6,
   parameter int HIST_W    = 3,
   parameter int MODE      = 2,
   parameter int RAS_DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   output logic             busy,
   input  logic             lk_valid,
   input  logic [31:0]      lk_pc,
   input  logic             lk_is_branch,
   input  logic             lk_is_call,
   input  logic             lk_is_ret,
   output logic             pred_taken,
   output logic [IDX_W-1:0] pred_index,
   output logic             ras_valid,
   output logic [31:0]      ras_target,
   input  logic             rs_valid,
   input  logic [IDX_W-1:0] rs_index,
   input  logic             rs_taken,
   input  logic             rs_pred,
   output logic [31:0]      perf_branches,
   output logic [31:0]      perf_hits
);

   localparam int ENTRIES = 1 << IDX_W;

   logic [1:0]        bht_r [ENTRIES];
   init_state_e       state_r, state_s;
   logic [IDX_W-1:0]  sweep_r;
   logic [HIST_W-1:0] gh_r;
   logic [31:0]       perf_branches_r, perf_hits_r;
   logic [IDX_W-1:0]  pc_idx_s, idx_s;
   logic              upd_s, ras_empty_s, ras_push_s, ras_pop_s;

   assign busy  = (state_r == ST_INIT) || !resetn;
   assign upd_s = rs_valid && !busy;

   assign pc_idx_s = lk_pc[IDX_W+1:2];

   // Table index selection; the shift form of concat keeps HIST_W == IDX_W legal
   always_comb begin
      idx_s = pc_idx_s;
      case (MODE)
         MODE_BIMODAL: idx_s = pc_idx_s;
         MODE_GSHARE:  idx_s = pc_idx_s ^ IDX_W'(gh_r);
         MODE_CONCAT:  idx_s = (pc_idx_s << HIST_W) | IDX_W'(gh_r);
         default:      idx_s = pc_idx_s;
      endcase
   end

   assign pred_index = idx_s;
   assign pred_taken = !busy && lk_is_branch && bht_r[idx_s][1];

   // Init FSM state register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_r <= ST_INIT;
      end else begin
         state_r <= state_s;
      end
   end

   // Init FSM next state: leave INIT once the last entry has been written
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_INIT: begin
            if (sweep_r == {IDX_W{1'b1}}) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_INIT;
            end
         end
         ST_RUN:  state_s = ST_RUN;
         default: state_s = ST_INIT;
      endcase
   end

   // Counter table: sweep to weakly not-taken, then saturating updates on resolve
   always_ff @(posedge clk) begin
      if (!resetn) begin
         sweep_r <= '0;
      end else if (state_r == ST_INIT) begin
         bht_r[sweep_r] <= CNT_WNT;
         sweep_r        <= sweep_r + IDX_W'(1);
      end else if (upd_s) begin
         bht_r[rs_index] <= sat_incdec(bht_r[rs_index], rs_taken);
      end
   end

   // Global history shifts the newest outcome in at the MSB; perf counters wrap
   always_ff @(posedge clk) begin
      if (!resetn) begin
         gh_r            <= '0;
         perf_branches_r <= 32'd0;
         perf_hits_r     <= 32'd0;
      end else if (upd_s) begin
         gh_r            <= (gh_r >> 1) | (HIST_W'(rs_taken) << (HIST_W - 1));
         perf_branches_r <= perf_branches_r + 32'd1;
         if (rs_pred == rs_taken) begin
            perf_hits_r <= perf_hits_r + 32'd1;
         end
      end
   end

   assign perf_branches = perf_branches_r;
   assign perf_hits     = perf_hits_r;

   assign ras_push_s = lk_valid && !busy && lk_is_call;
   assign ras_pop_s  = lk_valid && !busy && lk_is_ret;

   bpred_ras #(
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .resetn    (resetn),
      .push      (ras_push_s),
      .pop       (ras_pop_s),
      .push_data (lk_pc + 32'd4),
      .empty     (ras_empty_s),
      .top       (ras_target)
   );

   assign ras_valid = !ras_empty_s && lk_is_ret && !busy;

endmodule

// File: tb/tb_bpred_unit.sv
// Directed bench for bpred_unit: three instances (bimodal, gshare, concat) share stimulus.
module tb_bpred_unit;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        lk_valid = 1'b0, lk_is_branch = 1'b0, lk_is_call = 1'b0, lk_is_ret = 1'b0;
   logic [31:0] lk_pc = 32'h0;
   logic        rs_valid = 1'b0, rs_taken = 1'b0, rs_pred = 1'b0;
   logic [5:0]  rs_index = 6'd0;

   logic        busy0, busy1, busy2;
   logic        pt0, pt1, pt2;
   logic [5:0]  pi0, pi1, pi2;
   logic        rv0, rv1, rv2;
   logic [31:0] rt0, rt1, rt2;
   logic [31:0] pb0, pb1, pb2, ph0, ph1, ph2;

   always #5 clk = ~clk;

   bpred_unit #(.IDX_W(6), .HIST_W(3), .MODE(0), .RAS_DEPTH(4)) u0 (
      .clk(clk), .resetn(resetn), .busy(busy0), .lk_valid(lk_valid), .lk_pc(lk_pc),
      .lk_is_branch(lk_is_branch), .lk_is_call(lk_is_call), .lk_is_ret(lk_is_ret),
      .pred_taken(pt0), .pred_index(pi0), .ras_valid(rv0), .ras_target(rt0),
      .rs_valid(rs_valid), .rs_index(rs_index), .rs_taken(rs_taken), .rs_pred(rs_pred),
      .perf_branches(pb0), .perf_hits(ph0));

   bpred_unit #(.IDX_W(6), .HIST_W(3), .MODE(1), .RAS_DEPTH(4)) u1 (
      .clk(clk), .resetn(resetn), .busy(busy1), .lk_valid(lk_valid), .lk_pc(lk_pc),
      .lk_is_branch(lk_is_branch), .lk_is_call(lk_is_call), .lk_is_ret(lk_is_ret),
      .pred_taken(pt1), .pred_index(pi1), .ras_valid(rv1), .ras_target(rt1),
      .rs_valid(rs_valid), .rs_index(rs_index), .rs_taken(rs_taken), .rs_pred(rs_pred),
      .perf_branches(pb1), .perf_hits(ph1));

   bpred_unit #(.IDX_W(6), .HIST_W(3), .MODE(2), .RAS_DEPTH(4)) u2 (
      .clk(clk), .resetn(resetn), .busy(busy2), .lk_valid(lk_valid), .lk_pc(lk_pc),
      .lk_is_branch(lk_is_branch), .lk_is_call(lk_is_call), .lk_is_ret(lk_is_ret),
      .pred_taken(pt2), .pred_index(pi2), .ras_valid(rv2), .ras_target(rt2),
      .rs_valid(rs_valid), .rs_index(rs_index), .rs_taken(rs_taken), .rs_pred(rs_pred),
      .perf_branches(pb2), .perf_hits(ph2));

   typedef struct {
      logic        rs_valid;
      logic [5:0]  rs_index;
      logic        rs_taken;
      logic        rs_pred;
      logic [31:0] pc;
      logic        br;
      logic        exp_pred;
      logic [31:0] exp_br;
      logic [31:0] exp_hit;
   } vec_t;

   vec_t        vecs [7];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cycles;
   logic [31:0] ras_exp [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      lk_valid = 1'b0; lk_is_branch = 1'b0; lk_is_call = 1'b0; lk_is_ret = 1'b0;
      lk_pc = 32'h0; rs_valid = 1'b0; rs_taken = 1'b0; rs_pred = 1'b0; rs_index = 6'd0;
   endtask

   // Release reset and count cycles until busy drops (bounded)
   task automatic release_and_sweep(output int n);
      resetn = 1'b1;
      n = 0;
      while (busy0 && n < 200) begin
         tick();
         n++;
      end
   endtask

   initial begin
      // Test 1: reset state and sweep length
      idle_inputs();
      resetn = 1'b0;
      repeat (2) tick();
      lk_valid = 1'b1; lk_is_branch = 1'b1; lk_is_ret = 1'b1; lk_pc = 32'h40;
      #1;
      check("reset_busy", 32'(busy0), 32'd1);
      check("reset_pred_taken", 32'(pt2), 32'd0);
      check("reset_ras_valid", 32'(rv0), 32'd0);
      check("reset_perf_br", pb0, 32'd0);
      check("reset_perf_hit", ph0, 32'd0);
      release_and_sweep(cycles);
      check("sweep_cycles", 32'(cycles), 32'd64);
      check("busy_after_sweep", 32'(busy0 | busy1 | busy2), 32'd0);
      check("init_pred_0x40", 32'(pt2), 32'd0);
      check("init_pred_mode0_0x40", 32'(pt0), 32'd0);
      check("init_ras_valid_empty", 32'(rv0), 32'd0);

      // Test 2 + 5: MODE 0 counter at idx 16, table driven (pre-edge expectations)
      vecs[0] = '{1'b1, 6'd16, 1'b1, 1'b0, 32'h40, 1'b1, 1'b0, 32'd0, 32'd0};
      vecs[1] = '{1'b1, 6'd16, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'd1, 32'd0};
      vecs[2] = '{1'b1, 6'd16, 1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'd2, 32'd1};
      vecs[3] = '{1'b1, 6'd16, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'd3, 32'd2};
      vecs[4] = '{1'b1, 6'd16, 1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'd4, 32'd2};
      vecs[5] = '{1'b0, 6'd16, 1'b0, 1'b0, 32'h40, 1'b1, 1'b0, 32'd5, 32'd2};
      vecs[6] = '{1'b0, 6'd16, 1'b0, 1'b0, 32'h40, 1'b0, 1'b0, 32'd5, 32'd2};
      idle_inputs();
      for (int i = 0; i < 7; i++) begin
         lk_valid = 1'b1;
         lk_pc = vecs[i].pc; lk_is_branch = vecs[i].br;
         rs_valid = vecs[i].rs_valid; rs_index = vecs[i].rs_index;
         rs_taken = vecs[i].rs_taken; rs_pred = vecs[i].rs_pred;
         #1;
         check($sformatf("vec%0d_pred", i), 32'(pt0), 32'(vecs[i].exp_pred));
         check($sformatf("vec%0d_index", i), 32'(pi0), 32'd16);
         check($sformatf("vec%0d_perf_br", i), pb0, vecs[i].exp_br);
         check($sformatf("vec%0d_perf_hit", i), ph0, vecs[i].exp_hit);
         tick();
      end

      // Test 3: GH after T, NT, T = 3'b101
      idle_inputs();
      resetn = 1'b0;
      repeat (2) tick();
      release_and_sweep(cycles);
      check("sweep2_cycles", 32'(cycles), 32'd64);
      rs_valid = 1'b1; rs_index = 6'd0;
      rs_taken = 1'b1; tick();
      rs_taken = 1'b0; tick();
      rs_taken = 1'b1; tick();
      idle_inputs();
      lk_valid = 1'b1; lk_is_branch = 1'b1; lk_pc = 32'h0;
      #1;
      check("gshare_idx_pc0", 32'(pi1), 32'h05);
      check("bimodal_idx_pc0", 32'(pi0), 32'h00);
      check("bimodal_pred_idx0", 32'(pt0), 32'd1);
      lk_pc = 32'h1C;
      #1;
      check("concat_idx_pc1c", 32'(pi2), 32'h3D);
      check("gshare_idx_pc1c", 32'(pi1), 32'h02);
      check("bimodal_idx_pc1c", 32'(pi0), 32'h07);
      check("perf_br_t3", pb0, 32'd3);
      check("perf_hit_t3", ph0, 32'd1);

      // Test 4: RAS push/pop, overflow, empty pop, call+ret replace
      idle_inputs();
      lk_valid = 1'b1; lk_is_ret = 1'b1;
      #1;
      check("ras_empty_valid", 32'(rv0), 32'd0);
      check("ras_empty_target", rt0, 32'h0);
      tick();
      lk_valid = 1'b0; lk_is_ret = 1'b0; lk_is_call = 1'b1; lk_pc = 32'h700;
      tick();
      lk_valid = 1'b1; lk_is_call = 1'b0; lk_is_ret = 1'b1;
      #1;
      check("ras_no_push_when_invalid", 32'(rv0), 32'd0);
      lk_is_ret = 1'b0; lk_is_call = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         lk_pc = 32'(k) * 32'h100;
         tick();
      end
      ras_exp[0] = 32'h504; ras_exp[1] = 32'h404; ras_exp[2] = 32'h304; ras_exp[3] = 32'h204;
      lk_is_call = 1'b0; lk_is_ret = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check($sformatf("ras_pop%0d_valid", k), 32'(rv0), 32'd1);
         check($sformatf("ras_pop%0d_target", k), rt0, ras_exp[k]);
         tick();
      end
      check("ras_after_pops_valid", 32'(rv0), 32'd0);
      check("ras_after_pops_target", rt0, 32'h0);
      tick();
      lk_is_ret = 1'b0; lk_is_call = 1'b1; lk_pc = 32'h100;
      tick();
      lk_is_ret = 1'b1; lk_pc = 32'h600;
      #1;
      check("ras_callret_pre_top", rt0, 32'h104);
      tick();
      lk_is_call = 1'b0;
      #1;
      check("ras_callret_valid", 32'(rv0), 32'd1);
      check("ras_callret_top", rt0, 32'h604);
      tick();
      check("ras_callret_then_empty", 32'(rv0), 32'd0);

      // Test 6: reset during sweep restarts it; resolves during busy are ignored
      idle_inputs();
      resetn = 1'b0;
      repeat (2) tick();
      resetn = 1'b1;
      rs_valid = 1'b1; rs_index = 6'd0; rs_taken = 1'b1; rs_pred = 1'b1;
      repeat (20) tick();
      check("busy_at_cycle20", 32'(busy0), 32'd1);
      resetn = 1'b0;
      #1;
      check("busy_in_reset", 32'(busy0), 32'd1);
      tick();
      check("busy_after_reset_edge", 32'(busy0), 32'd1);
      resetn = 1'b1;
      cycles = 0;
      while (busy0 && cycles < 200) begin
         tick();
         cycles++;
      end
      rs_valid = 1'b0;
      check("sweep_restart_cycles", 32'(cycles), 32'd64);
      check("perf_br_after_restart", pb0, 32'd0);
      check("perf_hit_after_restart", ph0, 32'd0);
      lk_valid = 1'b1; lk_is_branch = 1'b1; lk_pc = 32'h0;
      #1;
      check("idx0_reinit_pred", 32'(pt0), 32'd0);
      check("gshare_idx_gh_cleared", 32'(pi1), 32'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit so the bench can never hang
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
